// File: rtl/apb_event_unit_ng.sv
// APB event unit: sticky IRQ/event pending registers, lowest-index IRQ ID, sleep/wake FSM.
// Zero wait states; PRDATA is combinational while PSEL is high; outputs come from registers.
// No backpressure (PREADY tied high). Optional macro EVENT_UNIT_EDGE_EN selects rising-edge capture.
module apb_event_unit_ng #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_LINES      = 32,
    parameter int WAKE_CYCLES    = 2
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_LINES-1:0]      irq_i,
    input  logic [NUM_LINES-1:0]      event_i,
    output logic [NUM_LINES-1:0]      irq_o,
    output logic                      fetch_enable_o,
    output logic                      clk_gate_core_o,
    input  logic                      core_busy_i
);

    localparam logic [31:0] LINE_MASK = (NUM_LINES >= 32) ? 32'hFFFF_FFFF
                                                          : ((32'd1 << NUM_LINES) - 32'd1);
    localparam logic [3:0]  WAKE_LOAD = 4'(WAKE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_WAIT_IDLE = 3'd1,
        ST_SLEEP     = 3'd2,
        ST_WAKE      = 3'd3
    } state_t;

    state_t      state;
    logic [3:0]  wake_cnt;
    logic [31:0] irq_en, irq_pend, evt_en, evt_pend;
    logic [31:0] irq_in, evt_in, irq_cap, evt_cap, irq_out;
    logic [31:0] irq_set_wr, irq_clr_wr, evt_clr_wr;
    logic [3:0]  idx;
    logic        mapped, wr, sleep_req, wake;
    logic [4:0]  irq_id_idx;
    logic        unused_addr;

    assign idx         = PADDR[5:2];
    assign mapped      = (idx <= 4'd8);
    assign wr          = PSEL & PENABLE & PWRITE;
    assign unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0]};

    assign irq_in  = 32'(irq_i) & LINE_MASK;
    assign evt_in  = 32'(event_i) & LINE_MASK;
    assign irq_out = irq_pend & irq_en;
    assign irq_o   = irq_out[NUM_LINES-1:0];

    assign irq_set_wr = (wr && idx == 4'd2) ? (PWDATA & LINE_MASK) : 32'd0;
    assign irq_clr_wr = (wr && idx == 4'd3) ? PWDATA : 32'd0;
    assign evt_clr_wr = (wr && idx == 4'd6) ? PWDATA : 32'd0;
    assign sleep_req  = wr && (idx == 4'd7) && PWDATA[0];
    assign wake       = (|irq_out) | (|(evt_pend & evt_en));

`ifdef EVENT_UNIT_EDGE_EN
    logic [31:0] irq_q, evt_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_q <= 32'd0;
            evt_q <= 32'd0;
        end else begin
            irq_q <= irq_in;
            evt_q <= evt_in;
        end
    end

    assign irq_cap = irq_in & ~irq_q;
    assign evt_cap = evt_in & ~evt_q;
`else
    assign irq_cap = irq_in;
    assign evt_cap = evt_in;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_en   <= 32'd0;
            evt_en   <= 32'd0;
            irq_pend <= 32'd0;
            evt_pend <= 32'd0;
        end else begin
            if (wr && idx == 4'd0) irq_en <= PWDATA & LINE_MASK;
            if (wr && idx == 4'd4) evt_en <= PWDATA & LINE_MASK;
            // Set and capture are OR-ed in after the clear so they win a same-cycle collision.
            irq_pend <= (irq_pend & ~irq_clr_wr) | irq_set_wr | irq_cap;
            evt_pend <= (evt_pend & ~evt_clr_wr) | evt_cap;
        end
    end

    always_comb begin
        irq_id_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (irq_out[i]) irq_id_idx = 5'(i);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state           <= ST_RUN;
            wake_cnt        <= 4'd0;
            fetch_enable_o  <= 1'b1;
            clk_gate_core_o <= 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (sleep_req) begin
                        state           <= ST_WAIT_IDLE;
                        fetch_enable_o  <= 1'b0;
                        clk_gate_core_o <= 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (wake) begin
                        state           <= ST_RUN;
                        fetch_enable_o  <= 1'b1;
                        clk_gate_core_o <= 1'b1;
                    end else if (!core_busy_i) begin
                        state           <= ST_SLEEP;
                        fetch_enable_o  <= 1'b0;
                        clk_gate_core_o <= 1'b0;
                    end
                end
                ST_SLEEP: begin
                    if (wake) begin
                        state           <= ST_WAKE;
                        wake_cnt        <= WAKE_LOAD;
                        fetch_enable_o  <= 1'b0;
                        clk_gate_core_o <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt == 4'd0) begin
                        state           <= ST_RUN;
                        fetch_enable_o  <= 1'b1;
                        clk_gate_core_o <= 1'b1;
                    end else begin
                        wake_cnt <= wake_cnt - 4'd1;
                    end
                end
                default: begin
                    state           <= ST_RUN;
                    fetch_enable_o  <= 1'b1;
                    clk_gate_core_o <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        PRDATA = 32'd0;
        if (PSEL) begin
            case (idx)
                4'd0:    PRDATA = irq_en;
                4'd1:    PRDATA = irq_pend;
                4'd4:    PRDATA = evt_en;
                4'd5:    PRDATA = evt_pend;
                4'd7:    PRDATA = {29'd0, state};
                4'd8:    PRDATA = {|irq_out, 26'd0, irq_id_idx};
                default: PRDATA = 32'd0;
            endcase
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL & PENABLE & ~mapped;

endmodule
